// File: rtl/fifo_blk_ctrl.sv
// First-word-fall-through FIFO controller in front of a single-clock dual-port
// block RAM. The RAM has a registered read port and bypasses a same-cycle write
// to the read address. This block owns the pointers and occupancy, and presents
// the RAM read data as a valid/pop head-of-queue stream.
`timescale 1ns/1ps
module fifo_blk_ctrl #(
    parameter int DATAWIDTH = 4,
    parameter int ADDRWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 we,
    output logic                 full,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd,
    output logic [ADDRWIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic [DATAWIDTH-1:0] ram_wr_data,
    output logic [ADDRWIDTH-1:0] ram_wr_addr,
    output logic                 ram_we,
    output logic [ADDRWIDTH-1:0] ram_rd_addr,
    input  logic [DATAWIDTH-1:0] ram_rd_data
);

    localparam logic [ADDRWIDTH:0] DEPTH_CNT = (ADDRWIDTH+1)'(2**ADDRWIDTH);

    logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTH:0]   count_q, count_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic                 push, pop, fetch;
    logic [ADDRWIDTH:0]   pending;

    // Handshake decode; full is judged on the registered count, so a pop in the
    // same cycle never makes room for a push.
    assign push    = we & ~full_q;
    assign pop     = rd & rd_valid_q;
    assign pending = count_q - {{ADDRWIDTH{1'b0}}, rd_valid_q};
    assign fetch   = ((pending != '0) | push) & (~rd_valid_q | pop);

    assign ram_we      = push & ~reset;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_wr_data = wr_data;
    // When idle, re-read the head's own slot so the registered RAM output
    // keeps showing the same word.
    assign ram_rd_addr = fetch ? rd_ptr_q : rd_ptr_q - ADDRWIDTH'(1);

    assign rd_data   = ram_rd_data;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Next-state for pointers, occupancy, head-valid and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = fetch | (rd_valid_q & ~pop);
        overflow_d  = overflow_q | (we & full_q);
        underflow_d = underflow_q | (rd & ~rd_valid_q);

        if (push)
            wr_ptr_d = wr_ptr_q + ADDRWIDTH'(1);
        if (fetch)
            rd_ptr_d = rd_ptr_q + ADDRWIDTH'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDRWIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDRWIDTH+1)'(1);
            default: count_d = count_q;
        endcase

        full_d = (count_d == DEPTH_CNT);
    end

    // State registers with synchronous reset; any in-flight RAM word is simply
    // abandoned because rd_valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_blk_ctrl.sv
// Bench for fifo_blk_ctrl: behavioural dual-port RAM with write bypass, a
// queue-based reference FIFO, directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_fifo_blk_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] wr_data;
    logic          we;
    logic          full;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_wr_addr;
    logic          ram_we;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    fifo_blk_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .we(we), .full(full),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd(rd), .count(count),
        .overflow(overflow), .underflow(underflow), .ram_wr_data(ram_wr_data),
        .ram_wr_addr(ram_wr_addr), .ram_we(ram_we), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Attached RAM: registered read port, write-to-read-address bypass.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_we && ram_wr_addr == ram_rd_addr) ram_rd_data <= ram_wr_data;
        else ram_rd_data <= mem[ram_rd_addr];
    end

    // Reference model state.
    logic [DW-1:0] m_q[$];
    bit            m_ovf, m_udf;
    int            m_wr_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check write port before the edge, update model, check after.
    task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic p);
        bit exp_push;
        reset   = r;
        we      = w;
        wr_data = d;
        rd      = p;
        #1;
        exp_push = w && !r && (m_q.size() < DEPTH);
        chk("ram_we", 32'(ram_we), 32'(exp_push));
        if (exp_push) begin
            chk("ram_wr_addr", 32'(ram_wr_addr), 32'(m_wr_cnt % DEPTH));
            chk("ram_wr_data", 32'(ram_wr_data), 32'(d));
        end
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_ovf    = 0;
            m_udf    = 0;
            m_wr_cnt = 0;
        end else begin
            if (w && m_q.size() == DEPTH) m_ovf = 1;
            if (p && m_q.size() == 0) m_udf = 1;
            if (p && m_q.size() > 0) void'(m_q.pop_front());
            if (exp_push) begin
                m_q.push_back(d);
                m_wr_cnt++;
            end
        end
        #1;
        chk("count", 32'(count), 32'(m_q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
        if (m_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
    endtask

    initial begin
        int pw, pr;
        reset = 1'b1; we = 1'b0; rd = 1'b0; wr_data = '0;
        m_ovf = 0; m_udf = 0; m_wr_cnt = 0;
        @(posedge clk); #1;
        step(1, 0, 8'h00, 0);

        // Reset then idle.
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0);

        // Single word, hold, pop.
        step(0, 1, 8'hA5, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);

        // Fill, overflow attempt, drain.
        for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0);
        step(0, 1, 8'hEE, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Wrap-around streaming at occupancy 3.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0);
        for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom), 1);

        // Pop with nothing pending while pushing 0x3C.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h3C, 1);
        step(0, 0, 8'h00, 0);

        // Push and pop while full.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom), 0);
        step(0, 1, 8'h77, 1);
        step(0, 0, 8'h00, 1);

        // Underflow on empty, sticky until reset.
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h5A, 0);
        step(0, 0, 8'h00, 1);

        // Reset mid-stream at count 5, with a push request during reset.
        for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
        step(1, 1, 8'h99, 1);
        step(0, 0, 8'h00, 0);

        // Random traffic with shifting push/pop bias.
        for (int blk = 0; blk < 8; blk++) begin
            pw = $urandom_range(90, 10);
            pr = $urandom_range(90, 10);
            for (int i = 0; i < 60; i++)
                step(($urandom_range(199) == 0), ($urandom_range(99) < pw),
                     8'($urandom), ($urandom_range(99) < pr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_blk_ctrl.md
# fifo_blk_ctrl

Synchronous first-word-fall-through FIFO controller that drives the write and read ports of a single-clock dual-port block RAM. The RAM's read port is registered, and a same-cycle write to the read address is bypassed to the read data. Sits directly in front of the RAM: it generates write enable and addresses from a push interface and turns the RAM's registered read data into a valid/pop stream. Used for UART/bus buffering between pipeline stages.

## Interface
- DATAWIDTH, 4, word width; must match the attached RAM.
- ADDRWIDTH, 4, RAM address width; FIFO depth = 2^ADDRWIDTH words.

- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_data  in  DATAWIDTH  push data.
- we  in  1  push request.
- full  out  1  occupancy == 2^ADDRWIDTH (registered).
- rd_data  out  DATAWIDTH  head word; valid only when rd_valid = 1.
- rd_valid  out  1  head word present (registered).
- rd  in  1  pop request; acts only when rd_valid = 1.
- count  out  ADDRWIDTH+1  total occupancy, including the head word.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while rd_valid = 0.
- ram_wr_data  out  DATAWIDTH  RAM write data (= wr_data).
- ram_wr_addr  out  ADDRWIDTH  RAM write address.
- ram_we  out  1  RAM write enable.
- ram_rd_addr  out  ADDRWIDTH  RAM read address, sampled every cycle.
- ram_rd_data  in  DATAWIDTH  RAM registered read data.

## Operation
- State: wr_ptr and rd_ptr (ADDRWIDTH bits, wrap modulo 2^ADDRWIDTH), count (ADDRWIDTH+1 bits), rd_valid, overflow, underflow.
- push = we & ~full. pop = rd & rd_valid.
- Write path: ram_we = push, ram_wr_addr = wr_ptr, ram_wr_data = wr_data. On push, wr_ptr += 1.
- pending = count − rd_valid, i.e. words in RAM not yet fetched to the head.
- fetch = (pending != 0 | push) & (~rd_valid | pop).
- ram_rd_addr = fetch ? rd_ptr : rd_ptr − 1 (mod 2^ADDRWIDTH). When the block is not fetching, the RAM re-reads the slot of the displayed head, so rd_data holds steady.
- On fetch, rd_ptr += 1.
- Next rd_valid = fetch | (rd_valid & ~pop).
- rd_data = ram_rd_data. This is a combinational pass-through; there is no extra register.
- The head word's slot stays reserved until it is popped, so a write can never overwrite the displayed word.
- count next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- full = (count == 2^ADDRWIDTH). Push while full is dropped and sets overflow. This applies even if a pop occurs in the same cycle, because full is evaluated on the registered count.
- rd while rd_valid = 0 is ignored and sets underflow.
- overflow and underflow clear only on reset.
- Reset (any cycle, including mid-burst): wr_ptr = rd_ptr = 0, count = 0, rd_valid = 0, full = 0, overflow = underflow = 0. In-flight RAM data is discarded. ram_we is 0 during the reset cycle.

## Timing
- Push into an empty FIFO at cycle N: RAM write and fetch of the same address occur in cycle N, and the RAM bypasses the write. rd_valid = 1 and rd_data = that word at N+1. Latency is 1 cycle.
- Pop at cycle N with pending ≥ 1: the next word is presented at N+1, with rd_valid staying 1. Back-to-back pops sustain 1 word/cycle.
- Pop at cycle N with pending = 0 and no push: rd_valid = 0 at N+1.
- Pop at N with pending = 0 and a push at N: the new word appears at N+1 via bypass, with no bubble.
- count, full, rd_valid, overflow, underflow are registered and update at the edge after the causing cycle.
- Throughput: 1 push and 1 pop per cycle sustained at any occupancy between 1 and depth−1.

## Test plan
- Reset then idle: all outputs 0 and ram_we = 0 for 10 cycles. Assert reset mid-stream (count = 5): count = 0 and rd_valid = 0 on the next cycle.
- Single word (ADDRWIDTH = 4, DATAWIDTH = 8): push 0xA5 at cycle N -> rd_valid = 1 and rd_data = 0xA5 at N+1, count = 1. Hold with rd = 0 for 5 cycles -> rd_data stays 0xA5. Pop -> rd_valid = 0 and count = 0.
- Fill: push 0x00..0x0F with no pops -> full = 1 and count = 16 after the 16th push. 17th push -> dropped, overflow = 1, count stays 16. Drain 16 pops -> data 0x00..0x0F in order, then rd_valid = 0.
- Wrap-around: 40 words streamed with simultaneous push/pop at occupancy 3 -> output sequence matches input exactly across pointer wrap, count constant at 3.
- Edge cases: pop with pending = 0 in the same cycle as a push of 0x3C -> rd_data = 0x3C next cycle with rd_valid continuous. Push and pop while full -> push rejected, count goes 16 -> 15.
- Underflow: rd = 1 on an empty FIFO -> underflow = 1, count stays 0, pointers unchanged. The flag stays set until reset.
